brp: RTL and testbench

BRP -- requirements
Module: brp

---
 rtl/brp.sv | 91 +++++++++
 tb/tb_brp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/brp.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by word PC,
// a branch outcome decoder, and a saturating misprediction counter.
module brp #(
  parameter int DATA_SIZE  = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_SIZE-1:0] i_fetch_pc,
  output logic                 o_pred_taken,
  input  logic                 i_upd_valid,
  input  logic [DATA_SIZE-1:0] i_upd_pc,
  input  logic [2:0]           i_upd_funct3,
  input  logic                 i_upd_pred,
  input  logic                 i_brc_equal,
  input  logic                 i_brc_less,
  output logic                 o_actual_taken,
  output logic                 o_mispredict,
  output logic [CNT_BITS-1:0]  o_mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  legal_f3;
  logic                  legal_upd;
  logic                  taken_raw;
  logic [1:0]            upd_cur;
  logic [1:0]            upd_next;
  logic [CNT_BITS-1:0]   mispred_cnt_q;
  logic                  unused_pc_bits;

  assign fetch_idx = i_fetch_pc[INDEX_BITS+1:2];
  assign upd_idx   = i_upd_pc[INDEX_BITS+1:2];

  assign unused_pc_bits = ^{i_fetch_pc[DATA_SIZE-1:INDEX_BITS+2], i_fetch_pc[1:0],
                            i_upd_pc[DATA_SIZE-1:INDEX_BITS+2], i_upd_pc[1:0]};

  // Read is from the registered table only, so a same-cycle update is not bypassed.
  assign o_pred_taken = table_q[fetch_idx][1];

  // funct3 010/011 are not branch encodings.
  assign legal_f3  = (i_upd_funct3[2:1] != 2'b01);
  assign legal_upd = i_upd_valid & legal_f3;

  always_comb begin
    taken_raw = 1'b0;
    case (i_upd_funct3)
      3'b000:         taken_raw = i_brc_equal;
      3'b001:         taken_raw = ~i_brc_equal;
      3'b100, 3'b110: taken_raw = i_brc_less;
      3'b101, 3'b111: taken_raw = ~i_brc_less;
      default:        taken_raw = 1'b0;
    endcase
  end

  assign o_actual_taken = legal_upd & taken_raw;
  assign o_mispredict   = legal_upd & (taken_raw != i_upd_pred);

  always_comb begin
    upd_cur  = table_q[upd_idx];
    upd_next = upd_cur;
    if (taken_raw) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
    end else if (legal_upd) begin
      table_q[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mispred_cnt_q <= '0;
    end else if (o_mispredict && (mispred_cnt_q != {CNT_BITS{1'b1}})) begin
      mispred_cnt_q <= mispred_cnt_q + CNT_BITS'(1);
    end
  end

  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_brp.sv
// Scoreboard bench for brp: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_brp;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_funct3;
  logic        upd_pred;
  logic        brc_equal;
  logic        brc_less;
  logic        actual_taken;
  logic        mispredict;
  logic [15:0] mispred_cnt;

  typedef struct {
    string       name;
    logic        pred;
    logic        act;
    logic        mis;
    logic [15:0] cnt;
    bit          chk_upd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  brp #(.DATA_SIZE(32), .INDEX_BITS(4), .CNT_BITS(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fetch_pc     (fetch_pc),
    .o_pred_taken   (pred_taken),
    .i_upd_valid    (upd_valid),
    .i_upd_pc       (upd_pc),
    .i_upd_funct3   (upd_funct3),
    .i_upd_pred     (upd_pred),
    .i_brc_equal    (brc_equal),
    .i_brc_less     (brc_less),
    .o_actual_taken (actual_taken),
    .o_mispredict   (mispredict),
    .o_mispred_cnt  (mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input string fld, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "pred", {15'd0, pred_taken}, {15'd0, e.pred});
      cmp(e.name, "cnt", mispred_cnt, e.cnt);
      if (e.chk_upd) begin
        cmp(e.name, "actual", {15'd0, actual_taken}, {15'd0, e.act});
        cmp(e.name, "mispredict", {15'd0, mispredict}, {15'd0, e.mis});
      end
    end
  end

  task automatic drive(input logic [31:0] fpc, input logic v, input logic [31:0] upc,
                       input logic [2:0] f3, input logic p, input logic eq, input logic lt);
    @(posedge clk);
    #1;
    fetch_pc   = fpc;
    upd_valid  = v;
    upd_pc     = upc;
    upd_funct3 = f3;
    upd_pred   = p;
    brc_equal  = eq;
    brc_less   = lt;
  endtask

  task automatic expect_cyc(input string nm, input logic ep, input logic ea, input logic em,
                            input logic [15:0] ec, input bit cu);
    exp_t e;
    e.name = nm; e.pred = ep; e.act = ea; e.mis = em; e.cnt = ec; e.chk_upd = cu;
    sb.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [31:0] fpc, input logic v, input logic [31:0] upc,
                     input logic [2:0] f3, input logic p, input logic eq, input logic lt,
                     input logic ep, input logic ea, input logic em, input logic [15:0] ec);
    drive(fpc, v, upc, f3, p, eq, lt);
    expect_cyc(nm, ep, ea, em, ec, 1'b1);
  endtask

  task automatic idle(input string nm, input logic [31:0] fpc, input logic ep, input logic [15:0] ec);
    cyc(nm, fpc, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, ep, 1'b0, 1'b0, ec);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_funct3 = '0;
    upd_pred = 1'b0; brc_equal = 1'b0; brc_less = 1'b0;

    // Taken update during reset must be dropped.
    drive(32'h40, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0);
    expect_cyc("rst_upd", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    drive(32'h40, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0);
    expect_cyc("rst_upd2", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    drive(32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_cyc("rst_exit", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 16; i++) idle("sweep", 32'(i << 2), 1'b0, 16'd0);

    // BEQ taken at 0x40 predicted NT twice: 01 -> 10 -> 11.
    cyc("beq1", 32'h40, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    cyc("beq2", 32'h40, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1);
    idle("beq_after", 32'h40, 1'b1, 16'd2);

    // Decode sweep at 0x4C with equal=0, less=1, pred=0.
    cyc("f3_000", 32'h4C, 1'b1, 32'h4C, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    cyc("f3_001", 32'h4C, 1'b1, 32'h4C, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2);
    cyc("f3_100", 32'h4C, 1'b1, 32'h4C, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3);
    cyc("f3_101", 32'h4C, 1'b1, 32'h4C, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);
    cyc("f3_110", 32'h4C, 1'b1, 32'h4C, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4);
    cyc("f3_111", 32'h4C, 1'b1, 32'h4C, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
    cyc("f3_010", 32'h4C, 1'b1, 32'h4C, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc("f3_011", 32'h4C, 1'b1, 32'h4C, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    // Entry still 01, so one taken update must make it predict taken.
    cyc("f3_probe", 32'h4C, 1'b1, 32'h4C, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    idle("f3_unchg", 32'h4C, 1'b1, 16'd5);

    // Not-taken saturation at 0x44.
    for (int i = 0; i < 4; i++)
      cyc("nt_sat", 32'h44, 1'b1, 32'h44, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    cyc("nt_probe", 32'h44, 1'b1, 32'h44, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);
    idle("nt_floor", 32'h44, 1'b0, 16'd6);

    // Same-index fetch/update: no bypass.
    cyc("nobyp", 32'h48, 1'b1, 32'h88, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6);
    idle("nobyp_next", 32'h48, 1'b1, 16'd6);
    idle("hold_e0", 32'h40, 1'b1, 16'd6);
    idle("hold_e4", 32'h50, 1'b0, 16'd6);

    // Counter saturation.
    drive(32'h40, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    force dut.mispred_cnt_q = 16'hFFFE;
    #1;
    release dut.mispred_cnt_q;
    expect_cyc("cnt_forced", 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b1);
    cyc("sat1", 32'h40, 1'b1, 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE);
    cyc("sat2", 32'h40, 1'b1, 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    cyc("sat3", 32'h40, 1'b1, 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    idle("sat_hold", 32'h40, 1'b0, 16'hFFFF);
    idle("pre_rst", 32'h48, 1'b1, 16'hFFFF);

    // Asynchronous reset between edges.
    drive(32'h48, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    expect_cyc("async_rst", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    drive(32'h40, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_cyc("post_rst_e0", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    // First edge after release applies the update.
    cyc("first_edge", 32'h40, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    idle("first_edge_after", 32'h40, 1'b1, 16'd1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
